// File: rtl/bsg_mla_pipe_with_v.sv
// Elastic valid-tagged register pipeline with ready/valid backpressure,
// bubble collapsing, synchronous flush and an occupancy count.
module bsg_mla_pipe_with_v #(
  parameter int width_p = -1,
  parameter int depth_p = 2,
  localparam int count_w_lp = $clog2(depth_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [width_p-1:0]    data_i,
  input  logic                  v_i,
  output logic                  ready_o,
  output logic [width_p-1:0]    data_o,
  output logic                  v_o,
  input  logic                  ready_and_i,
  input  logic                  flush_i,
  output logic [count_w_lp-1:0] count_o
);

  logic [depth_p-1:0] v_r;
  logic [depth_p-1:0] v_in;
  logic [depth_p-1:0] move;
  logic [width_p-1:0] data_r [depth_p];
  logic [width_p-1:0] d_in   [depth_p];
  logic [count_w_lp-1:0] cnt;

  // A stage may advance when it is empty or any stage downstream of it is
  // empty, or the consumer takes the output: this is what collapses bubbles.
  always_comb begin
    move = '0;
    for (int k = 0; k < depth_p; k++) begin
      logic tail_full;
      tail_full = 1'b1;
      for (int j = k; j < depth_p; j++) begin
        tail_full = tail_full & v_r[j];
      end
      move[k] = ready_and_i | ~tail_full;
    end
  end

  always_comb begin
    v_in    = '0;
    v_in[0] = v_i;
    d_in[0] = data_i;
    for (int k = 1; k < depth_p; k++) begin
      v_in[k] = v_r[k-1];
      d_in[k] = data_r[k-1];
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < depth_p; k++) begin
      cnt = cnt + count_w_lp'(v_r[k]);
    end
  end

  // Stage valids: the only state that sees reset or flush
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_r <= '0;
    end else if (flush_i) begin
      v_r <= '0;
    end else begin
      for (int k = 0; k < depth_p; k++) begin
        if (move[k]) v_r[k] <= v_in[k];
      end
    end
  end

  // Stage data: loaded only with a valid beat, otherwise held
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < depth_p; k++) begin
      if (move[k] && v_in[k]) data_r[k] <= d_in[k];
    end
  end

  assign ready_o = move[0];
  assign v_o     = v_r[depth_p-1];
  assign data_o  = data_r[depth_p-1];
  assign count_o = cnt;

endmodule

// File: tb/tb_bsg_mla_pipe_with_v.sv
// Directed and randomized checks of bsg_mla_pipe_with_v at depths 1, 3 and 4,
// all instances sharing one stimulus stream.
module tb_bsg_mla_pipe_with_v;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       v_i;
  logic       ready_and_i;
  logic       flush_i;
  logic [7:0] data_i;

  logic       rdy1, v1;
  logic [7:0] d1;
  logic [0:0] c1;
  logic       rdy3, v3;
  logic [7:0] d3;
  logic [1:0] c3;
  logic       rdy4, v4;
  logic [7:0] d4;
  logic [2:0] c4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bsg_mla_pipe_with_v #(.width_p(8), .depth_p(1)) u1 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_o(rdy1),
    .data_o(d1), .v_o(v1), .ready_and_i(ready_and_i), .flush_i(flush_i), .count_o(c1));

  bsg_mla_pipe_with_v #(.width_p(8), .depth_p(3)) u3 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_o(rdy3),
    .data_o(d3), .v_o(v3), .ready_and_i(ready_and_i), .flush_i(flush_i), .count_o(c3));

  bsg_mla_pipe_with_v #(.width_p(8), .depth_p(4)) u4 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_o(rdy4),
    .data_o(d4), .v_o(v4), .ready_and_i(ready_and_i), .flush_i(flush_i), .count_o(c4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #3;
    reset_i = 1'b0;
    step();
  endtask

  // Scoreboard state for the random phase: circular buffer per instance
  int         dep [3] = '{1, 3, 4};
  logic [7:0] mem [3][16];
  int         head[3];
  int         sz  [3];

  initial begin
    logic       o_r, o_v;
    logic [7:0] o_d;
    int         o_c;
    logic       acc[3], ret[3];
    logic [7:0] din;

    reset_i = 1'b1; v_i = 1'b0; ready_and_i = 1'b1; flush_i = 1'b0; data_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_v_o", v3, 0);
    check("rst_count", c3, 0);
    check("rst_ready", rdy3, 1);
    #1 reset_i = 1'b0;
    step();

    // 1: three back-to-back beats with the consumer always ready
    v_i = 1'b1; data_i = 8'hA1; step();
    check("t1_cnt_e1", c3, 1);
    check("t1_v_e1", v3, 0);
    data_i = 8'hA2; step();
    check("t1_cnt_e2", c3, 2);
    data_i = 8'hA3; step();
    v_i = 1'b0;
    check("t1_v_e3", v3, 1);
    check("t1_d_e3", d3, 8'hA1);
    check("t1_cnt_peak", c3, 3);
    step();
    check("t1_d_e4", d3, 8'hA2);
    check("t1_cnt_e4", c3, 2);
    step();
    check("t1_d_e5", d3, 8'hA3);
    step();
    check("t1_v_drained", v3, 0);
    check("t1_cnt_drained", c3, 0);

    // 2: consumer stalled, fourth beat blocked until it releases
    do_reset();
    ready_and_i = 1'b0;
    v_i = 1'b1; data_i = 8'hB1; step();
    check("t2_d1_hold", d1, 8'hB1);
    check("t2_d1_ready", rdy1, 0);
    data_i = 8'hB2; step();
    data_i = 8'hB3; step();
    data_i = 8'hB4;
    #1;
    check("t2_ready_full", rdy3, 0);
    check("t2_cnt_full", c3, 3);
    step();
    check("t2_hold_d", d3, 8'hB1);
    check("t2_hold_cnt", c3, 3);
    ready_and_i = 1'b1;
    #1;
    check("t2_ready_comb", rdy3, 1);
    check("t2_d1_ready_comb", rdy1, 1);
    step();
    v_i = 1'b0;
    check("t2_cnt_swap", c3, 3);
    check("t2_d_e5", d3, 8'hB2);
    step();
    check("t2_d_e6", d3, 8'hB3);
    step();
    check("t2_d_e7", d3, 8'hB4);
    step();
    check("t2_empty", v3, 0);

    // 3: a lone beat falls through to the last stage, then the pipe fills
    do_reset();
    ready_and_i = 1'b0;
    v_i = 1'b1; data_i = 8'hC1; step();
    v_i = 1'b0;
    step(); step(); step();
    check("t3_v_last", v4, 1);
    check("t3_d_last", d4, 8'hC1);
    check("t3_cnt1", c4, 1);
    v_i = 1'b1;
    data_i = 8'hC2;
    #1 check("t3_rdy_c2", rdy4, 1);
    step();
    data_i = 8'hC3;
    #1 check("t3_rdy_c3", rdy4, 1);
    step();
    data_i = 8'hC4;
    #1 check("t3_rdy_c4", rdy4, 1);
    step();
    v_i = 1'b0;
    check("t3_cnt_full", c4, 4);
    check("t3_ready_full", rdy4, 0);
    ready_and_i = 1'b1;
    step(); check("t3_out_c2", d4, 8'hC2);
    step(); check("t3_out_c3", d4, 8'hC3);
    step(); check("t3_out_c4", d4, 8'hC4);

    // 4: flush with two beats held and a third offered
    do_reset();
    ready_and_i = 1'b0;
    v_i = 1'b1; data_i = 8'hD1; step();
    data_i = 8'hD2; step();
    check("t4_cnt_pre", c3, 2);
    data_i = 8'hD3; flush_i = 1'b1; step();
    flush_i = 1'b0; v_i = 1'b0;
    check("t4_v_post", v3, 0);
    check("t4_cnt_post", c3, 0);
    ready_and_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_no_emerge", v3, 0);
    end

    // 5: asynchronous reset between edges, then a fresh beat
    v_i = 1'b1; data_i = 8'hE1; step();
    data_i = 8'hE2; step();
    data_i = 8'hE3; step();
    check("t5_v_pre", v3, 1);
    #2 reset_i = 1'b1;
    #1;
    check("t5_v_async", v3, 0);
    check("t5_cnt_async", c3, 0);
    check("t5_rdy_async", rdy3, 1);
    @(posedge clk);
    #3 reset_i = 1'b0;
    v_i = 1'b1; data_i = 8'h5A; step();
    v_i = 1'b0;
    check("t5_v_e1", v3, 0);
    step();
    check("t5_v_e2", v3, 0);
    step();
    check("t5_v_e3", v3, 1);
    check("t5_d_e3", d3, 8'h5A);

    // 6: random traffic against a FIFO scoreboard per instance
    do_reset();
    for (int i = 0; i < 3; i++) begin
      head[i] = 0;
      sz[i]   = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      v_i = 1'($urandom_range(0, 1));
      data_i = 8'($urandom);
      ready_and_i = ($urandom_range(0, 3) != 0);
      din = data_i;
      #1;
      for (int i = 0; i < 3; i++) begin
        case (i)
          0: begin o_r = rdy1; o_v = v1; o_d = d1; o_c = int'(c1); end
          1: begin o_r = rdy3; o_v = v3; o_d = d3; o_c = int'(c3); end
          default: begin o_r = rdy4; o_v = v4; o_d = d4; o_c = int'(c4); end
        endcase
        check("rnd_ready", o_r, (sz[i] < dep[i]) || ready_and_i);
        check("rnd_count", o_c, sz[i]);
        if (o_v) begin
          check("rnd_nonempty", sz[i] > 0, 1);
          check("rnd_data", o_d, mem[i][head[i]]);
        end
        acc[i] = v_i & o_r;
        ret[i] = o_v & ready_and_i;
      end
      step();
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) mem[i][(head[i] + sz[i]) % 16] = din;
        if (acc[i]) sz[i]++;
        if (ret[i] && sz[i] > 0) begin
          head[i] = (head[i] + 1) % 16;
          sz[i]--;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
